// File: rtl/serial_sub5.sv
// Bit-serial WIDTH-bit subtractor: res = Ain - Bin - Bi (mod 2^WIDTH), bo = borrow-out.
// Latency: start sampled at edge E0, busy after E0..E0+WIDTH, done pulse and result after E0+WIDTH.
// Backpressure: none; start is accepted only in IDLE/DONE and silently ignored while busy.
module serial_sub5 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic             Bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             bo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sd;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic             r_bo;
  logic [CW-1:0]    r_cnt;

  logic             w_load;
  logic             w_last;
  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_nxt;

  // Full-subtractor cell working on the LSBs of the operand shift registers.
  assign w_a      = r_sa[0];
  assign w_b      = r_sb[0];
  assign w_d      = w_a ^ w_b ^ r_br;
  assign w_br_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign res  = r_res;
  assign bo   = r_bo;

  // State register; reset wins over everything, including an in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; DONE accepts start exactly like IDLE so operations can run back-to-back.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next = S_SHIFT;
          w_load = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, shift one bit per SHIFT cycle, publish result on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_sd  <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      r_res <= '0;
      r_bo  <= 1'b0;
    end else if (w_load) begin
      r_sa  <= Ain;
      r_sb  <= Bin;
      r_br  <= Bi;
      r_cnt <= '0;
      r_sd  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
      r_sd  <= {w_d, r_sd[WIDTH-1:1]};
      r_br  <= w_br_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_res <= {w_d, r_sd[WIDTH-1:1]};
        r_bo  <= w_br_nxt;
      end
    end
  end

endmodule
